// File: rtl/nonsym_check_pkg.sv
// rtl/nonsym_check_pkg.sv - shared types and constants for the nonsym pattern checker
package nonsym_check_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  typedef enum logic [1:0] {PM_COUNTER, PM_LFSR, PM_WALK, PM_CONST} pattern_mode_t;

  // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] NO_ERR_IDX = 32'hFFFF_FFFF;

endpackage

// File: rtl/nonsym_pattern_gen.sv
// rtl/nonsym_pattern_gen.sv - pattern generator presenting two words per beat
module nonsym_pattern_gen
  import nonsym_check_pkg::*;
#(
  parameter int HALF_W = 32
) (
  input  logic              okClk,
  input  logic              reset_n,
  input  logic              reload,
  input  logic              step,
  input  pattern_mode_t     pattern_mode,
  input  logic [HALF_W-1:0] pattern_seed,
  output logic [HALF_W-1:0] cur_word,
  output logic [HALF_W-1:0] next_word
);

  function automatic logic [HALF_W-1:0] seed_word(input pattern_mode_t m, input logic [HALF_W-1:0] s);
    case (m)
      PM_LFSR: seed_word = (s == '0) ? HALF_W'(1) : s;
      PM_WALK: seed_word = HALF_W'(1);
      default: seed_word = s;
    endcase
  endfunction

  function automatic logic [HALF_W-1:0] step_word(input pattern_mode_t m, input logic [HALF_W-1:0] w);
    case (m)
      PM_COUNTER: step_word = w + HALF_W'(1);
      PM_LFSR:    step_word = (w >> 1) ^ (w[0] ? HALF_W'(LFSR_TAPS) : '0);
      PM_WALK:    step_word = {w[HALF_W-2:0], w[HALF_W-1]};
      default:    step_word = w;
    endcase
  endfunction

  pattern_mode_t     mode_q, eff_mode;
  logic [HALF_W-1:0] word_q;
  logic              fresh_q;

  // Until the first reload or step the generator follows the live seed rule.
  assign eff_mode  = fresh_q ? pattern_mode : mode_q;
  assign cur_word  = fresh_q ? seed_word(pattern_mode, pattern_seed) : word_q;
  assign next_word = step_word(eff_mode, cur_word);

  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      fresh_q <= 1'b1;
      mode_q  <= PM_COUNTER;
      word_q  <= '0;
    end else if (reload) begin
      fresh_q <= 1'b0;
      mode_q  <= pattern_mode;
      word_q  <= seed_word(pattern_mode, pattern_seed);
    end else if (step) begin
      fresh_q <= 1'b0;
      mode_q  <= eff_mode;
      word_q  <= step_word(eff_mode, next_word);
    end
  end

endmodule

// File: rtl/nonsym_pattern_checker.sv
// rtl/nonsym_pattern_checker.sv - FIFO pattern checker; CHECKER_FIRST_ERR_EN enables first-error capture
module nonsym_pattern_checker
  import nonsym_check_pkg::*;
#(
  parameter int HALF_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                okClk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                reset_pattern,
  input  logic                clear_errors,
  input  logic [1:0]          pattern_mode,
  input  logic [HALF_W-1:0]   pattern_seed,
  input  logic [CNT_W-1:0]    expected_beats,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic                fifo_valid,
  input  logic [2*HALF_W-1:0] fifo_dout,
  output logic                busy,
  output logic                done,
  output logic                extra_data,
  output logic [CNT_W-1:0]    word_count,
  output logic [CNT_W-1:0]    error_count,
  output logic [CNT_W-1:0]    first_err_index,
  output logic [HALF_W-1:0]   first_err_data
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issued_q;
  logic [HALF_W-1:0] cur_word, next_word;
  logic              run, arm, check, mism_lo, mism_hi, last_beat;
  logic [1:0]        n_err;
  logic [CNT_W:0]    wc_plus2, err_sum;

  assign run       = (state_q == ST_RUN);
  assign arm       = start && !run;
  assign check     = fifo_valid && run;
  assign mism_lo   = fifo_dout[HALF_W-1:0] != cur_word;
  assign mism_hi   = fifo_dout[2*HALF_W-1:HALF_W] != next_word;
  assign n_err     = {1'b0, mism_lo} + {1'b0, mism_hi};
  assign wc_plus2  = {1'b0, word_count} + (CNT_W+1)'(2);
  assign err_sum   = {1'b0, error_count} + (CNT_W+1)'(n_err);
  assign last_beat = check && (expected_beats != '0) && (wc_plus2 == {expected_beats, 1'b0});

  assign fifo_rd_en = run && !fifo_empty && ((expected_beats == '0) || (issued_q < expected_beats));
  assign busy       = run;
  assign done       = (state_q == ST_DONE);

  nonsym_pattern_gen #(.HALF_W(HALF_W)) u_gen (
    .okClk        (okClk),
    .reset_n      (reset_n),
    .reload       (arm || reset_pattern),
    .step         (check),
    .pattern_mode (pattern_mode_t'(pattern_mode)),
    .pattern_seed (pattern_seed),
    .cur_word     (cur_word),
    .next_word    (next_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (last_beat) state_d = ST_DONE;
      default: if (start) state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      issued_q   <= '0;
      word_count <= '0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        issued_q   <= '0;
        word_count <= '0;
      end else begin
        if (fifo_rd_en) issued_q <= issued_q + CNT_W'(1);
        if (check) word_count <= wc_plus2[CNT_W-1:0];
      end
    end
  end

  // Beats outside RUN are only flagged; clear_errors overrides everything here.
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      error_count <= '0;
      extra_data  <= 1'b0;
    end else if (clear_errors) begin
      error_count <= '0;
      extra_data  <= 1'b0;
    end else begin
      if (check) error_count <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      if (fifo_valid && !run) extra_data <= 1'b1;
    end
  end

`ifdef CHECKER_FIRST_ERR_EN
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      first_err_index <= CNT_W'(NO_ERR_IDX);
      first_err_data  <= '0;
    end else if (clear_errors) begin
      first_err_index <= CNT_W'(NO_ERR_IDX);
      first_err_data  <= '0;
    end else if (check && (first_err_index == CNT_W'(NO_ERR_IDX)) && (mism_lo || mism_hi)) begin
      first_err_index <= mism_lo ? word_count : word_count + CNT_W'(1);
      first_err_data  <= mism_lo ? fifo_dout[HALF_W-1:0] : fifo_dout[2*HALF_W-1:HALF_W];
    end
  end
`else
  assign first_err_index = CNT_W'(NO_ERR_IDX);
  assign first_err_data  = '0;
`endif

endmodule

// File: tb/tb_nonsym_pattern_checker.sv
// tb/tb_nonsym_pattern_checker.sv - self-checking bench for nonsym_pattern_checker
module tb_nonsym_pattern_checker;

`ifdef CHECKER_FIRST_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif
  localparam logic [31:0] NOE  = 32'hFFFF_FFFF;
  localparam logic [31:0] CORR = 32'h0000_0100;

  logic        okClk = 1'b0, reset_n = 1'b0;
  logic        start = 1'b0, reset_pattern = 1'b0, clear_errors = 1'b0;
  logic [1:0]  pattern_mode = 2'd0;
  logic [31:0] pattern_seed = 32'd0, expected_beats = 32'd0;
  logic        fifo_empty = 1'b1, fifo_valid = 1'b0;
  logic [63:0] fifo_dout = 64'd0;
  logic        fifo_rd_en, busy, done, extra_data;
  logic [31:0] word_count, error_count, first_err_index, first_err_data;
  logic        s_rd_en, s_busy, s_done, s_extra;
  logic [1:0]  s_wc, s_ec, s_idx;
  logic [31:0] s_data;

  nonsym_pattern_checker dut (
    .okClk(okClk), .reset_n(reset_n), .start(start), .reset_pattern(reset_pattern),
    .clear_errors(clear_errors), .pattern_mode(pattern_mode), .pattern_seed(pattern_seed),
    .expected_beats(expected_beats), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_valid(fifo_valid), .fifo_dout(fifo_dout), .busy(busy), .done(done),
    .extra_data(extra_data), .word_count(word_count), .error_count(error_count),
    .first_err_index(first_err_index), .first_err_data(first_err_data)
  );

  nonsym_pattern_checker #(.HALF_W(32), .CNT_W(2)) dut_sat (
    .okClk(okClk), .reset_n(reset_n), .start(start), .reset_pattern(reset_pattern),
    .clear_errors(clear_errors), .pattern_mode(pattern_mode), .pattern_seed(pattern_seed),
    .expected_beats(2'd0), .fifo_empty(fifo_empty), .fifo_rd_en(s_rd_en),
    .fifo_valid(fifo_valid), .fifo_dout(fifo_dout), .busy(s_busy), .done(s_done),
    .extra_data(s_extra), .word_count(s_wc), .error_count(s_ec),
    .first_err_index(s_idx), .first_err_data(s_data)
  );

  initial forever #5 okClk = ~okClk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: a read accepted at a rising edge yields data for the following edge.
  logic [63:0] fq[$];
  bit          took = 1'b0;
  logic        inj_valid = 1'b0;
  logic [63:0] inj_dout = 64'd0;
  int          rd_cnt = 0;

  always @(negedge okClk) begin
    #1;
    if (took && fq.size() > 0) begin
      fifo_dout  = fq.pop_front();
      fifo_valid = 1'b1;
    end else begin
      fifo_valid = inj_valid;
      fifo_dout  = inj_dout;
    end
    fifo_empty = (fq.size() == 0);
    #1;
    took = fifo_rd_en;
    if (took) rd_cnt++;
  end

  function automatic logic [31:0] galois(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] ref_word(input logic [1:0] mode, input logic [31:0] seed, input int k);
    logic [31:0] s;
    case (mode)
      2'd0: return seed + 32'(k);
      2'd1: begin
        s = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < k; i++) s = galois(s);
        return s;
      end
      2'd2: return 32'h1 << (k % 32);
      default: return seed;
    endcase
  endfunction

  task automatic beat(input logic [63:0] d, input bit clr, input bit rp, input bit st);
    @(negedge okClk);
    inj_valid = 1'b1; inj_dout = d; clear_errors = clr; reset_pattern = rp; start = st;
    @(negedge okClk);
    inj_valid = 1'b0; clear_errors = 1'b0; reset_pattern = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge okClk);
      n++;
    end
  endtask

  task automatic run_case(input logic [1:0] mode, input logic [31:0] seed, input int beats,
                          input logic [31:0] lo_m, input logic [31:0] hi_m,
                          input int exp_err, input logic [31:0] exp_idx);
    logic [31:0] w0, w1, fdata;
    bit found = 1'b0;
    fdata = 32'd0;
    @(negedge okClk);
    pattern_mode = mode; pattern_seed = seed; expected_beats = beats; clear_errors = 1'b1;
    for (int b = 0; b < beats; b++) begin
      w0 = ref_word(mode, seed, 2*b);
      w1 = ref_word(mode, seed, 2*b + 1);
      if (lo_m[b]) w0 ^= CORR;
      if (hi_m[b]) w1 ^= CORR;
      if (!found && lo_m[b]) begin found = 1'b1; fdata = w0; end
      else if (!found && hi_m[b]) begin found = 1'b1; fdata = w1; end
      fq.push_back({w1, w0});
    end
    @(negedge okClk); clear_errors = 1'b0; start = 1'b1;
    @(negedge okClk); start = 1'b0;
    wait_done();
    chk("run_done", 64'(done), 64'(1));
    chk("run_word_count", 64'(word_count), 64'(2*beats));
    chk("run_error_count", 64'(error_count), 64'(exp_err));
    chk("run_first_err_index", 64'(first_err_index), 64'(FE_EN ? exp_idx : NOE));
    chk("run_first_err_data", 64'(first_err_data), 64'(FE_EN ? fdata : 32'd0));
    chk("run_extra_data", 64'(extra_data), 64'(0));
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] seed;
    int          beats;
    logic [31:0] lo_m;
    logic [31:0] hi_m;
    int          exp_err;
    logic [31:0] exp_idx;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [1:0]  r_mode;
    logic [31:0] r_seed, r_lo, r_hi, r_idx;
    int          r_beats, rd_base;

    tbl[0] = '{2'd0, 32'hFFFF_FFFE, 4,  32'h0,  32'h0,  0, NOE};
    tbl[1] = '{2'd1, 32'h0,         4,  32'h0,  32'h4,  1, 32'd5};
    tbl[2] = '{2'd2, 32'h1234_5678, 20, 32'h0,  32'h0,  0, NOE};
    tbl[3] = '{2'd3, 32'hA5A5_A5A5, 3,  32'h2,  32'h2,  2, 32'd2};
    tbl[4] = '{2'd1, 32'hDEAD_BEEF, 6,  32'h21, 32'h20, 3, 32'd0};
    tbl[5] = '{2'd0, 32'h0,         5,  32'h0,  32'h10, 1, 32'd9};

    repeat (3) @(negedge okClk);
    chk("rst_rd_en_low", 64'(fifo_rd_en), 64'(0));
    reset_n = 1'b1;
    @(negedge okClk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_extra", 64'(extra_data), 64'(0));
    chk("rst_word_count", 64'(word_count), 64'(0));
    chk("rst_error_count", 64'(error_count), 64'(0));
    chk("rst_first_err_index", 64'(first_err_index), 64'(NOE));
    chk("rst_first_err_data", 64'(first_err_data), 64'(0));

    for (int i = 0; i < 6; i++)
      run_case(tbl[i].mode, tbl[i].seed, tbl[i].beats, tbl[i].lo_m, tbl[i].hi_m,
               tbl[i].exp_err, tbl[i].exp_idx);

    for (int r = 0; r < 8; r++) begin
      r_mode  = 2'($urandom_range(0, 3));
      r_seed  = (r == 0) ? 32'd0 : $urandom;
      r_beats = int'($urandom_range(1, 12));
      r_lo    = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom & ((32'd1 << r_beats) - 32'd1));
      r_hi    = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom & ((32'd1 << r_beats) - 32'd1));
      r_idx   = NOE;
      for (int w = 0; w < 2*r_beats && r_idx == NOE; w++)
        if ((w % 2 == 0) ? r_lo[w/2] : r_hi[w/2]) r_idx = 32'(w);
      run_case(r_mode, r_seed, r_beats, r_lo, r_hi, $countones(r_lo) + $countones(r_hi), r_idx);
    end

    // Read limit: 5 beats queued, only 3 may be requested.
    @(negedge okClk);
    pattern_mode = 2'd0; pattern_seed = 32'd0; expected_beats = 32'd3; clear_errors = 1'b1;
    for (int b = 0; b < 5; b++) fq.push_back({32'(2*b + 1), 32'(2*b)});
    @(negedge okClk); clear_errors = 1'b0; start = 1'b1; rd_base = rd_cnt;
    @(negedge okClk); start = 1'b0;
    wait_done();
    repeat (3) @(negedge okClk);
    chk("lim_done", 64'(done), 64'(1));
    chk("lim_rd_cycles", 64'(rd_cnt - rd_base), 64'(3));
    chk("lim_left_in_fifo", 64'(fq.size()), 64'(2));
    chk("lim_extra", 64'(extra_data), 64'(0));
    chk("lim_errors", 64'(error_count), 64'(0));
    fq.delete();

    // Unbounded run: deferred mode change, reset_pattern timing, clear priority.
    @(negedge okClk);
    pattern_mode = 2'd3; pattern_seed = 32'd0; expected_beats = 32'd0; clear_errors = 1'b1;
    @(negedge okClk); clear_errors = 1'b0; start = 1'b1;
    @(negedge okClk); start = 1'b0;
    beat(64'd0, 1'b0, 1'b0, 1'b0);
    chk("ub_busy", 64'(busy), 64'(1));
    chk("ub_err_a", 64'(error_count), 64'(0));
    pattern_mode = 2'd0; pattern_seed = 32'd5;
    beat(64'd0, 1'b0, 1'b0, 1'b0);
    chk("ub_mode_deferred", 64'(error_count), 64'(0));
    beat(64'd0, 1'b0, 1'b1, 1'b0);
    chk("ub_reload_old_value", 64'(error_count), 64'(0));
    beat({32'd6, 32'd5}, 1'b0, 1'b0, 1'b0);
    chk("ub_reload_new_value", 64'(error_count), 64'(0));
    chk("ub_word_count", 64'(word_count), 64'(8));
    beat(64'd0, 1'b0, 1'b0, 1'b0);
    chk("ub_two_errors", 64'(error_count), 64'(2));
    chk("ub_first_idx", 64'(first_err_index), 64'(FE_EN ? 32'd8 : NOE));
    beat(64'd0, 1'b1, 1'b0, 1'b0);
    chk("clr_wins_count", 64'(error_count), 64'(0));
    chk("clr_wins_idx", 64'(first_err_index), 64'(NOE));
    chk("clr_word_count", 64'(word_count), 64'(12));

    @(negedge okClk);
    reset_n = 1'b0; fq.push_back(64'd0); fq.push_back(64'd0);
    #3;
    chk("abort_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_word_count", 64'(word_count), 64'(0));
    chk("abort_error_count", 64'(error_count), 64'(0));
    @(negedge okClk);
    reset_n = 1'b1; fq.delete();

    // Beat while idle.
    beat(64'h1234, 1'b0, 1'b0, 1'b0);
    chk("idle_extra", 64'(extra_data), 64'(1));
    chk("idle_word_count", 64'(word_count), 64'(0));
    chk("idle_errors", 64'(error_count), 64'(0));
    @(negedge okClk); clear_errors = 1'b1;
    @(negedge okClk); clear_errors = 1'b0;
    chk("idle_extra_cleared", 64'(extra_data), 64'(0));

    // start coincident with a beat while in DONE.
    run_case(2'd3, 32'h77, 2, 32'h0, 32'h0, 0, NOE);
    expected_beats = 32'd1; pattern_mode = 2'd3; pattern_seed = 32'h99;
    beat(64'd0, 1'b0, 1'b0, 1'b1);
    chk("done_start_extra", 64'(extra_data), 64'(1));
    chk("done_start_busy", 64'(busy), 64'(1));
    chk("done_start_wc", 64'(word_count), 64'(0));
    chk("done_start_err", 64'(error_count), 64'(0));
    fq.push_back({32'h99, 32'h99});
    wait_done();
    chk("done_start_finish", 64'(done), 64'(1));
    chk("done_start_wc2", 64'(word_count), 64'(2));
    chk("done_start_err2", 64'(error_count), 64'(0));

    // Saturation on the narrow-counter instance.
    @(negedge okClk);
    pattern_mode = 2'd3; pattern_seed = 32'd0; expected_beats = 32'd0; clear_errors = 1'b1;
    @(negedge okClk); clear_errors = 1'b0; start = 1'b1;
    @(negedge okClk); start = 1'b0; reset_pattern = 1'b1;
    @(negedge okClk); reset_pattern = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 1'b0);
      chk("sat_count", 64'(s_ec), 64'((i == 0) ? 2 : 3));
      chk("wide_count", 64'(error_count), 64'(2*(i + 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
